// File: rtl/piano_pkg.sv
// Shared constants and types for the note synthesiser: base note table,
// FSM state encoding and octave-select codes.
package piano_pkg;

  localparam int NUM_NOTES = 7;

  // One octave starting at middle C, in integer Hz.
  localparam int FREQ [NUM_NOTES] = '{262, 294, 330, 349, 392, 440, 494};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    SUSTAIN = 2'd2
  } state_t;

  localparam logic [1:0] PITCH_MID  = 2'b00;
  localparam logic [1:0] PITCH_LOW  = 2'b01;
  localparam logic [1:0] PITCH_HIGH = 2'b10;

  // Keys past the end of the table continue upward, one octave per wrap.
  function automatic int note_freq(input int idx);
    return FREQ[idx % NUM_NOTES] << (idx / NUM_NOTES);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-bit switch debouncer: the output follows the raw input only after
// the raw level has differed from it for DEBOUNCE_CYC consecutive cycles.
// No synchroniser stage is added so the press latency stays DEBOUNCE_CYC.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] cnt;

  // Count consecutive disagreeing cycles; flip the level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (raw == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      level <= raw;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/note_synth.sv
// Key-driven square-wave tone generator with octave select and release
// sustain.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | silent, speaker held low, waiting for a debounced key
//   PLAY    | a key is held; speaker toggles every divisor cycles
//   SUSTAIN | keys released; last note keeps ringing for SUSTAIN_CYC
module note_synth #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int NUM_KEYS     = 7,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SUSTAIN_CYC  = 20_000_000,
  parameter int DIV_W        = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [1:0]          pitch,
  output logic                speaker,
  output logic [3:0]          note_idx,
  output logic [NUM_KEYS-1:0] key_db,
  output logic                sustaining
);

  import piano_pkg::*;

  localparam int SUS_W = (SUSTAIN_CYC > 1) ? $clog2(SUSTAIN_CYC) : 1;
  localparam logic [SUS_W-1:0] SUS_LOAD = SUS_W'((SUSTAIN_CYC > 0) ? SUSTAIN_CYC - 1 : 0);

  state_t             state_q, state_d;
  logic [3:0]         note_q, note_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [SUS_W-1:0]   sus_q, sus_d;
  logic               spk_q, spk_d;
  logic [3:0]         sel;
  logic [DIV_W-1:0]   div_tbl [16];
  logic [DIV_W-1:0]   div_sel, div_note;
  logic               tick_spk;
  logic [DIV_W-1:0]   tick_cnt;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (key[g]),
      .level (key_db[g])
    );
  end

  // Half-period table indexed directly by note number; entry 0 is silence.
  for (genvar g = 0; g < 16; g++) begin : g_div
    if (g >= 1 && g <= NUM_KEYS) begin : g_note
      assign div_tbl[g] = DIV_W'(CLK_HZ / (2 * note_freq(g - 1)));
    end else begin : g_none
      assign div_tbl[g] = '0;
    end
  end

  function automatic logic [DIV_W-1:0] pitch_scale(input logic [DIV_W-1:0] base,
                                                   input logic [1:0]       p);
    case (p)
      PITCH_LOW:  return base << 1;
      PITCH_HIGH: return base >> 1;
      default:    return base;
    endcase
  endfunction

  assign div_sel  = pitch_scale(div_tbl[sel], pitch);
  assign div_note = pitch_scale(div_tbl[note_q], pitch);

  // Fixed priority: lowest debounced key wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_db[i]) sel = 4'(i + 1);
    end
  end

  // One half-period step; the reload picks up the pitch in force right now.
  always_comb begin
    if (cnt_q == '0) begin
      tick_spk = ~spk_q;
      tick_cnt = div_note - DIV_W'(1);
    end else begin
      tick_spk = spk_q;
      tick_cnt = cnt_q - DIV_W'(1);
    end
  end

  // Next-state and datapath updates for the tone FSM.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    sus_d   = sus_q;
    spk_d   = spk_q;
    case (state_q)
      IDLE: begin
        spk_d  = 1'b0;
        note_d = '0;
        cnt_d  = '0;
        if (sel != '0) begin
          state_d = PLAY;
          note_d  = sel;
          cnt_d   = div_sel - DIV_W'(1);
        end
      end
      PLAY: begin
        if (sel == '0) begin
          if (SUSTAIN_CYC == 0) begin
            state_d = IDLE;
            note_d  = '0;
            cnt_d   = '0;
            spk_d   = 1'b0;
          end else begin
            state_d = SUSTAIN;
            sus_d   = SUS_LOAD;
            spk_d   = tick_spk;
            cnt_d   = tick_cnt;
          end
        end else if (sel != note_q) begin
          // Note change keeps the speaker phase, restarts the half-period.
          note_d = sel;
          cnt_d  = div_sel - DIV_W'(1);
        end else begin
          spk_d = tick_spk;
          cnt_d = tick_cnt;
        end
      end
      SUSTAIN: begin
        if (sel != '0) begin
          state_d = PLAY;
          note_d  = sel;
          cnt_d   = div_sel - DIV_W'(1);
        end else if (sus_q == '0) begin
          state_d = IDLE;
          note_d  = '0;
          cnt_d   = '0;
          spk_d   = 1'b0;
        end else begin
          sus_d = sus_q - SUS_W'(1);
          spk_d = tick_spk;
          cnt_d = tick_cnt;
        end
      end
      default: begin
        state_d = IDLE;
        note_d  = '0;
        cnt_d   = '0;
        spk_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      note_q  <= '0;
      cnt_q   <= '0;
      sus_q   <= '0;
      spk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      cnt_q   <= cnt_d;
      sus_q   <= sus_d;
      spk_q   <= spk_d;
    end
  end

  assign speaker    = spk_q;
  assign note_idx   = note_q;
  assign sustaining = (state_q == SUSTAIN);

endmodule
